bp_cce_mem_resp_delay: RTL and testbench

BP_CCE_MEM_RESP_DELAY -- requirements
Module: bp_cce_mem_resp_delay

---
 rtl/bp_cce_mem_resp_delay.sv | 162 ++++++++++++++++
 tb/tb_bp_cce_mem_resp_delay.sv | 556 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cce_mem_resp_delay.sv
// Delays memory responses toward the CCE: two independent in-order FIFOs hold each packet delay_p extra cycles.
// Performance counters are built only when BP_CCE_MEM_RESP_DELAY_PERF_EN is defined; otherwise they read 0.

module bp_cce_mem_resp_delay_chan #(
    parameter int unsigned width_p = 8,
    parameter int unsigned els_p   = 4,
    parameter int unsigned delay_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               ready_i
);
    localparam int unsigned         ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned         cnt_w_lp = ptr_w_lp + 1;
    localparam logic [7:0]          delay_lp = 8'(delay_p);
    localparam logic [cnt_w_lp-1:0] els_lp   = cnt_w_lp'(els_p);

    logic [width_p-1:0]  mem_r [els_p];
    logic [7:0]          age_r [els_p];
    logic [ptr_w_lp-1:0] rptr_r;
    logic [ptr_w_lp-1:0] wptr_r;
    logic [cnt_w_lp-1:0] cnt_r;
    logic [cnt_w_lp-1:0] cnt_n;
    logic                ready_r;
    logic                enq;
    logic                deq;

    assign enq     = v_i & ready_r;
    assign deq     = v_o & ready_i;
    assign cnt_n   = cnt_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    assign ready_o = ready_r;
    assign v_o     = (cnt_r != '0) && (age_r[rptr_r] == delay_lp);
    assign data_o  = mem_r[rptr_r];

    // Pointers, occupancy and saturating per-slot ages; ready is registered so it stays low in reset.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            cnt_r   <= '0;
            ready_r <= 1'b0;
            for (int i = 0; i < int'(els_p); i++) begin
                age_r[i] <= '0;
            end
        end else begin
            cnt_r   <= cnt_n;
            ready_r <= (cnt_n < els_lp);
            if (enq) begin
                wptr_r <= wptr_r + ptr_w_lp'(1);
            end
            if (deq) begin
                rptr_r <= rptr_r + ptr_w_lp'(1);
            end
            for (int i = 0; i < int'(els_p); i++) begin
                if (enq && (wptr_r == ptr_w_lp'(i))) begin
                    age_r[i] <= '0;
                end else if (age_r[i] != delay_lp) begin
                    age_r[i] <= age_r[i] + 8'd1;
                end
            end
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_r[wptr_r] <= data_i;
        end
    end
endmodule

module bp_cce_mem_resp_delay #(
    parameter int unsigned resp_width_p      = 64,
    parameter int unsigned data_resp_width_p = 576,
    parameter int unsigned els_p             = 4,
    parameter int unsigned delay_p           = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [resp_width_p-1:0]      mem_resp_i,
    input  logic                         mem_resp_v_i,
    output logic                         mem_resp_ready_o,
    input  logic [data_resp_width_p-1:0] mem_data_resp_i,
    input  logic                         mem_data_resp_v_i,
    output logic                         mem_data_resp_ready_o,
    output logic [resp_width_p-1:0]      mem_resp_o,
    output logic                         mem_resp_v_o,
    input  logic                         mem_resp_ready_i,
    output logic [data_resp_width_p-1:0] mem_data_resp_o,
    output logic                         mem_data_resp_v_o,
    input  logic                         mem_data_resp_ready_i,
    output logic [31:0]                  stall_cnt_o,
    output logic [31:0]                  release_cnt_o
);
    bp_cce_mem_resp_delay_chan #(
        .width_p (resp_width_p),
        .els_p   (els_p),
        .delay_p (delay_p)
    ) u_resp (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (mem_resp_i),
        .v_i     (mem_resp_v_i),
        .ready_o (mem_resp_ready_o),
        .data_o  (mem_resp_o),
        .v_o     (mem_resp_v_o),
        .ready_i (mem_resp_ready_i)
    );

    bp_cce_mem_resp_delay_chan #(
        .width_p (data_resp_width_p),
        .els_p   (els_p),
        .delay_p (delay_p)
    ) u_data_resp (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (mem_data_resp_i),
        .v_i     (mem_data_resp_v_i),
        .ready_o (mem_data_resp_ready_o),
        .data_o  (mem_data_resp_o),
        .v_o     (mem_data_resp_v_o),
        .ready_i (mem_data_resp_ready_i)
    );

`ifdef BP_CCE_MEM_RESP_DELAY_PERF_EN
    logic        stall_c;
    logic [1:0]  rel_inc_c;
    logic [32:0] stall_sum_c;
    logic [32:0] rel_sum_c;
    logic [31:0] stall_cnt_r;
    logic [31:0] release_cnt_r;

    assign stall_c     = (mem_resp_v_o & ~mem_resp_ready_i)
                       | (mem_data_resp_v_o & ~mem_data_resp_ready_i);
    assign rel_inc_c   = 2'(mem_resp_v_o & mem_resp_ready_i)
                       + 2'(mem_data_resp_v_o & mem_data_resp_ready_i);
    assign stall_sum_c = {1'b0, stall_cnt_r} + 33'(stall_c);
    assign rel_sum_c   = {1'b0, release_cnt_r} + 33'(rel_inc_c);

    // Saturating counters: a carry out of bit 31 pins the count at all ones.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stall_cnt_r   <= '0;
            release_cnt_r <= '0;
        end else begin
            stall_cnt_r   <= stall_sum_c[32] ? '1 : stall_sum_c[31:0];
            release_cnt_r <= rel_sum_c[32] ? '1 : rel_sum_c[31:0];
        end
    end

    assign stall_cnt_o   = stall_cnt_r;
    assign release_cnt_o = release_cnt_r;
`else
    assign stall_cnt_o   = '0;
    assign release_cnt_o = '0;
`endif
endmodule

// File: tb/tb_bp_cce_mem_resp_delay.sv
// Bench for bp_cce_mem_resp_delay: one instance with delay_p=8 and one with delay_p=0, checked
// against a queue-based reference model plus directed latency, full, stall, dual-release and reset scenarios.

module tb_bp_cce_mem_resp_delay;
    localparam int unsigned RW  = 16;
    localparam int unsigned DW  = 40;
    localparam int unsigned ELS = 4;
`ifdef BP_CCE_MEM_RESP_DELAY_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [RW-1:0] r_in  [2];
    logic [RW-1:0] r_out [2];
    logic          r_vi  [2];
    logic          r_ri  [2];
    logic          r_vo  [2];
    logic          r_rdy [2];
    logic [DW-1:0] d_in  [2];
    logic [DW-1:0] d_out [2];
    logic          d_vi  [2];
    logic          d_ri  [2];
    logic          d_vo  [2];
    logic          d_rdy [2];
    logic [31:0]   stall [2];
    logic [31:0]   rel   [2];

    int n_checks = 0;
    int n_fail   = 0;

    bp_cce_mem_resp_delay #(
        .resp_width_p(RW), .data_resp_width_p(DW), .els_p(ELS), .delay_p(8)
    ) u_dut0 (
        .clk_i(clk), .reset_i(rst),
        .mem_resp_i(r_in[0]), .mem_resp_v_i(r_vi[0]), .mem_resp_ready_o(r_ri[0]),
        .mem_data_resp_i(d_in[0]), .mem_data_resp_v_i(d_vi[0]), .mem_data_resp_ready_o(d_ri[0]),
        .mem_resp_o(r_out[0]), .mem_resp_v_o(r_vo[0]), .mem_resp_ready_i(r_rdy[0]),
        .mem_data_resp_o(d_out[0]), .mem_data_resp_v_o(d_vo[0]), .mem_data_resp_ready_i(d_rdy[0]),
        .stall_cnt_o(stall[0]), .release_cnt_o(rel[0])
    );

    bp_cce_mem_resp_delay #(
        .resp_width_p(RW), .data_resp_width_p(DW), .els_p(ELS), .delay_p(0)
    ) u_dut1 (
        .clk_i(clk), .reset_i(rst),
        .mem_resp_i(r_in[1]), .mem_resp_v_i(r_vi[1]), .mem_resp_ready_o(r_ri[1]),
        .mem_data_resp_i(d_in[1]), .mem_data_resp_v_i(d_vi[1]), .mem_data_resp_ready_o(d_ri[1]),
        .mem_resp_o(r_out[1]), .mem_resp_v_o(r_vo[1]), .mem_resp_ready_i(r_rdy[1]),
        .mem_data_resp_o(d_out[1]), .mem_data_resp_v_o(d_vo[1]), .mem_data_resp_ready_i(d_rdy[1]),
        .stall_cnt_o(stall[1]), .release_cnt_o(rel[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel index i = 2*instance + (0 resp, 1 data_resp)
    function automatic int del(int k);
        return (k == 0) ? 8 : 0;
    endfunction
    function automatic logic in_v(int i);
        return (i % 2 == 1) ? d_vi[i / 2] : r_vi[i / 2];
    endfunction
    function automatic logic in_rdy(int i);
        return (i % 2 == 1) ? d_rdy[i / 2] : r_rdy[i / 2];
    endfunction
    function automatic logic [63:0] in_data(int i);
        return (i % 2 == 1) ? 64'(d_in[i / 2]) : 64'(r_in[i / 2]);
    endfunction
    function automatic logic dut_v(int i);
        return (i % 2 == 1) ? d_vo[i / 2] : r_vo[i / 2];
    endfunction
    function automatic logic dut_rdy(int i);
        return (i % 2 == 1) ? d_ri[i / 2] : r_ri[i / 2];
    endfunction
    function automatic logic [63:0] dut_data(int i);
        return (i % 2 == 1) ? 64'(d_out[i / 2]) : 64'(r_out[i / 2]);
    endfunction

    // Reference model: a packet accepted in cycle t may leave from cycle t+1+delay onward.
    typedef struct {
        logic [63:0] d;
        int          t;
    } ent_t;
    ent_t mq [4][$];
    bit   blk = 1'b1;
    int   cyc = 0;
    int   m_stall [2];
    int   m_rel [2];

    function automatic bit m_v(int i);
        if (mq[i].size() == 0) return 1'b0;
        return cyc >= mq[i][0].t + 1 + del(i / 2);
    endfunction
    function automatic bit m_rdy(int i);
        return !blk && (mq[i].size() < int'(ELS));
    endfunction

    always @(posedge clk or negedge rst) begin : model
        bit   vv [4];
        bit   rr [4];
        ent_t e;
        if (!rst) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            blk = 1'b1;
            for (int k = 0; k < 2; k++) begin
                m_stall[k] = 0;
                m_rel[k]   = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                vv[i] = m_v(i);
                rr[i] = m_rdy(i);
            end
            for (int k = 0; k < 2; k++) begin
                if ((vv[2*k] && !in_rdy(2*k)) || (vv[2*k+1] && !in_rdy(2*k+1))) m_stall[k]++;
                m_rel[k] += int'(vv[2*k] && in_rdy(2*k)) + int'(vv[2*k+1] && in_rdy(2*k+1));
            end
            for (int i = 0; i < 4; i++) begin
                if (vv[i] && in_rdy(i)) void'(mq[i].pop_front());
                if (in_v(i) && rr[i]) begin
                    e.d = in_data(i);
                    e.t = cyc;
                    mq[i].push_back(e);
                end
            end
            blk = 1'b0;
            cyc++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (r_vo[k] !== 1'b0 || d_vo[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_v inst%0d: got %b/%b, required 0/0", k, r_vo[k], d_vo[k]);
            end
            n_checks++;
            if (r_ri[k] !== 1'b0 || d_ri[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready inst%0d: got %b/%b, required 0/0", k, r_ri[k], d_ri[k]);
            end
            n_checks++;
            if (stall[k] !== 32'd0 || rel[k] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_cnt inst%0d: got %0d/%0d, required 0/0", k, stall[k], rel[k]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (r_ri[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b, required 0", r_ri[0]);
        end
        tick;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (r_ri[k] !== 1'b1 || d_ri[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL ready_after_reset inst%0d: got %b/%b, required 1/1", k, r_ri[k], d_ri[k]);
            end
        end
        tick;
    endtask

    task automatic test_latency;
        logic [RW-1:0] p0, p1;
        int first0, first1, cnt0, cnt1;
        p0 = RW'($urandom);
        p1 = RW'($urandom);
        r_vi[0] = 1'b1; r_in[0] = p0;
        r_vi[1] = 1'b1; r_in[1] = p1;
        @(negedge clk);
        n_checks++;
        if (r_ri[0] !== 1'b1 || r_ri[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_accept: got %b/%b, required 1/1", r_ri[0], r_ri[1]);
        end
        tick;
        r_vi[0] = 1'b0;
        r_vi[1] = 1'b0;
        first0 = -1; first1 = -1; cnt0 = 0; cnt1 = 0;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            if (r_vo[0] === 1'b1) begin
                if (first0 < 0) first0 = n;
                cnt0++;
                n_checks++;
                if (r_out[0] !== p0) begin
                    n_fail++;
                    $display("FAIL latency_data_d8: got %h, required %h", r_out[0], p0);
                end
            end
            if (r_vo[1] === 1'b1) begin
                if (first1 < 0) first1 = n;
                cnt1++;
                n_checks++;
                if (r_out[1] !== p1) begin
                    n_fail++;
                    $display("FAIL latency_data_d0: got %h, required %h", r_out[1], p1);
                end
            end
            tick;
        end
        n_checks++;
        if (first0 != 9 || cnt0 != 1) begin
            n_fail++;
            $display("FAIL latency_d8: first at +%0d x%0d, required +9 x1", first0, cnt0);
        end
        n_checks++;
        if (first1 != 1 || cnt1 != 1) begin
            n_fail++;
            $display("FAIL latency_d0: first at +%0d x%0d, required +1 x1", first1, cnt1);
        end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] pk [4];
        int got;
        for (int i = 0; i < 4; i++) pk[i] = DW'({$urandom, $urandom});
        got = 0;
        for (int j = 0; j < 8; j++) begin
            d_vi[1] = (j < 4);
            d_in[1] = pk[j % 4];
            @(negedge clk);
            if (d_vo[1] === 1'b1) begin
                n_checks++;
                if (got > 3 || j != got + 1 || d_out[1] !== pk[got % 4]) begin
                    n_fail++;
                    $display("FAIL b2b_out%0d: got %h at +%0d, required %h at +%0d",
                             got, d_out[1], j, pk[got % 4], got + 1);
                end
                got++;
            end
            tick;
        end
        n_checks++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d, required 4", got);
        end
    endtask

    task automatic test_full;
        logic [63:0] pk [5];
        logic acc;
        int sent, got, found;
        for (int i = 0; i < 5; i++) pk[i] = {$urandom, $urandom};
        r_rdy[0] = 1'b0;
        sent = 0;
        for (int j = 0; j < 6; j++) begin
            r_vi[0] = 1'b1;
            r_in[0] = RW'(pk[sent]);
            @(negedge clk);
            acc = r_ri[0];
            tick;
            if (acc === 1'b1) sent++;
        end
        r_in[0] = RW'(pk[4]);
        @(negedge clk);
        n_checks++;
        if (sent != 4 || r_ri[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL full_accept: got %0d accepted ready=%b, required 4 ready=0", sent, r_ri[0]);
        end
        found = 0;
        for (int j = 0; j < 20; j++) begin
            if (r_vo[0] === 1'b1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (found != 1) begin
            n_fail++;
            $display("FAIL full_wait_v: got no valid, required valid within 20 cycles");
        end
        r_rdy[0] = 1'b1;
        #1;
        n_checks++;
        if (r_out[0] !== RW'(pk[0]) || r_ri[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL full_first_deq: got %h ready=%b, required %h ready=0", r_out[0], r_ri[0], RW'(pk[0]));
        end
        tick;
        r_rdy[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (r_ri[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL full_fifth_ready: got %b, required 1", r_ri[0]);
        end
        tick;
        r_vi[0] = 1'b0;
        r_rdy[0] = 1'b1;
        got = 1;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (r_vo[0] === 1'b1) begin
                n_checks++;
                if (got > 4 || r_out[0] !== RW'(pk[got % 5])) begin
                    n_fail++;
                    $display("FAIL full_drain%0d: got %h, required %h", got, r_out[0], RW'(pk[got % 5]));
                end
                got++;
            end
            tick;
        end
        n_checks++;
        if (got != 5) begin
            n_fail++;
            $display("FAIL full_drain_count: got %0d, required 5", got);
        end
    endtask

    task automatic test_long_stall;
        logic [RW-1:0] pk [3];
        logic [31:0] s0;
        int found;
        for (int i = 0; i < 3; i++) pk[i] = RW'($urandom);
        r_rdy[0] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            r_vi[0] = 1'b1;
            r_in[0] = pk[j];
            tick;
        end
        r_vi[0] = 1'b0;
        found = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (r_vo[0] === 1'b1) begin
                found = 1;
                break;
            end
        end
        n_checks++;
        if (found != 1) begin
            n_fail++;
            $display("FAIL stall_wait_v: got no valid, required valid within 20 cycles");
        end
        s0 = stall[0];
        repeat (300) tick;
        r_rdy[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_checks++;
            if (r_vo[0] !== 1'b1 || r_out[0] !== pk[j]) begin
                n_fail++;
                $display("FAIL stall_release%0d: got v=%b %h, required v=1 %h", j, r_vo[0], r_out[0], pk[j]);
            end
            if (j == 0) begin
                n_checks++;
                if (stall[0] - s0 !== 32'(PERF ? 300 : 0)) begin
                    n_fail++;
                    $display("FAIL stall_count: got %0d, required %0d", stall[0] - s0, PERF ? 300 : 0);
                end
            end
            tick;
        end
        @(negedge clk);
        n_checks++;
        if (r_vo[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_empty: got v=%b, required 0", r_vo[0]);
        end
        tick;
    endtask

    task automatic test_dual_release;
        logic [31:0] s;
        int found;
        r_vi[0] = 1'b1; r_in[0] = RW'($urandom);
        d_vi[0] = 1'b1; d_in[0] = DW'({$urandom, $urandom});
        tick;
        r_vi[0] = 1'b0;
        d_vi[0] = 1'b0;
        found = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (r_vo[0] === 1'b1) begin
                found = 1;
                break;
            end
        end
        n_checks++;
        if (found != 1 || d_vo[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL dual_both_valid: got found=%0d data_v=%b, required 1/1", found, d_vo[0]);
        end
        s = rel[0];
        tick;
        @(negedge clk);
        n_checks++;
        if (rel[0] - s !== 32'(PERF ? 2 : 0)) begin
            n_fail++;
            $display("FAIL dual_release_inc: got %0d, required %0d", rel[0] - s, PERF ? 2 : 0);
        end
        n_checks++;
        if (stall[0] !== 32'(PERF ? m_stall[0] : 0) || rel[0] !== 32'(PERF ? m_rel[0] : 0)) begin
            n_fail++;
            $display("FAIL dual_counters: got %0d/%0d, required %0d/%0d", stall[0], rel[0],
                     PERF ? m_stall[0] : 0, PERF ? m_rel[0] : 0);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        int found, seen;
        r_rdy[0] = 1'b0;
        for (int j = 0; j < 2; j++) begin
            r_vi[0] = 1'b1;
            r_in[0] = RW'($urandom);
            tick;
        end
        r_vi[0] = 1'b0;
        found = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (r_vo[0] === 1'b1) begin
                found = 1;
                break;
            end
        end
        n_checks++;
        if (found != 1) begin
            n_fail++;
            $display("FAIL rstmid_wait_v: got no valid, required valid within 20 cycles");
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (r_vo[0] !== 1'b0 || r_ri[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got v=%b ready=%b, required 0/0", r_vo[0], r_ri[0]);
        end
        n_checks++;
        if (stall[0] !== 32'd0 || rel[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_cnt: got %0d/%0d, required 0/0", stall[0], rel[0]);
        end
        tick;
        rst = 1'b1;
        r_rdy[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (r_ri[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_ready_early: got %b, required 0", r_ri[0]);
        end
        tick;
        seen = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (j == 0) begin
                n_checks++;
                if (r_ri[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rstmid_ready_rise: got %b, required 1", r_ri[0]);
                end
            end
            if (r_vo[0] === 1'b1) seen++;
            tick;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rstmid_no_stale: got %0d valid cycles, required 0", seen);
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 2; k++) begin
                r_vi[k]  = 1'($urandom_range(0, 1));
                d_vi[k]  = 1'($urandom_range(0, 1));
                r_rdy[k] = ($urandom_range(0, 2) != 0);
                d_rdy[k] = ($urandom_range(0, 2) != 0);
                r_in[k]  = RW'($urandom);
                d_in[k]  = DW'({$urandom, $urandom});
            end
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (dut_v(i) !== m_v(i) || dut_rdy(i) !== m_rdy(i)) begin
                    n_fail++;
                    $display("FAIL rand_hs ch%0d cyc%0d: got v=%b ready=%b, required v=%b ready=%b",
                             i, c, dut_v(i), dut_rdy(i), m_v(i), m_rdy(i));
                end
                if (m_v(i)) begin
                    n_checks++;
                    if (dut_data(i) !== mq[i][0].d) begin
                        n_fail++;
                        $display("FAIL rand_data ch%0d cyc%0d: got %h, required %h", i, c, dut_data(i), mq[i][0].d);
                    end
                end
            end
            tick;
        end
        for (int k = 0; k < 2; k++) begin
            r_vi[k] = 1'b0;
            d_vi[k] = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (stall[k] !== 32'(PERF ? m_stall[k] : 0) || rel[k] !== 32'(PERF ? m_rel[k] : 0)) begin
                n_fail++;
                $display("FAIL rand_counters inst%0d: got %0d/%0d, required %0d/%0d", k, stall[k], rel[k],
                         PERF ? m_stall[k] : 0, PERF ? m_rel[k] : 0);
            end
        end
        tick;
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            r_vi[k] = 1'b0; d_vi[k] = 1'b0;
            r_rdy[k] = 1'b1; d_rdy[k] = 1'b1;
            r_in[k] = '0; d_in[k] = '0;
        end
        test_reset;
        test_latency;
        test_back_to_back;
        test_full;
        test_long_stall;
        test_dual_release;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end
endmodule
